// File: rtl/kernel_sysid_regs.sv
// kernel_sysid_regs: system-ID register block with uptime counter, scratch and info words, read latency 1.
// Optional uptime counter, snapshot and CTRL register built when SYSID_UPTIME_EN is defined.
module kernel_sysid_regs #(
  parameter logic [31:0] SYSID_ID        = 32'h00000001,
  parameter logic [31:0] SYSID_TIMESTAMP = 32'd1503996230,
  parameter int          ADDR_W          = 3,
  parameter int          UPTIME_W        = 48
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);
  logic        w_wr;
  logic [31:0] r_scratch;
  logic [31:0] w_up_lo;
  logic [31:0] w_up_hi;
  logic [31:0] w_ctrl;
  logic [31:0] w_info;
  logic [31:0] w_rd;
  assign w_wr = write & ~read;
`ifdef SYSID_UPTIME_EN
  localparam logic FEAT = 1'b1;
  logic [UPTIME_W-1:0] r_cnt;
  logic [31:0]         r_hi;
  logic                r_freeze;
  logic [63:0]         w_cnt64;
  assign w_cnt64 = 64'(r_cnt);
  // Clear wins over increment; hi half is latched when the low half is read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_freeze <= 1'b0;
    end else begin
      r_cnt <= (w_wr && address == ADDR_W'(5) && writedata[0]) ? '0 :
               r_freeze ? r_cnt : r_cnt + UPTIME_W'(1);
      if (w_wr && address == ADDR_W'(5)) r_freeze <= writedata[1];
      if (read && address == ADDR_W'(2)) r_hi <= w_cnt64[63:32];
    end
  end
  assign w_up_lo = w_cnt64[31:0];
  assign w_up_hi = r_hi;
  assign w_ctrl  = {30'b0, r_freeze, 1'b0};
`else
  localparam logic FEAT = 1'b0;
  assign w_up_lo = '0;
  assign w_up_hi = '0;
  assign w_ctrl  = '0;
`endif
  assign w_info = {15'b0, FEAT, 4'b0, 4'(ADDR_W), 8'(UPTIME_W)};
  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_W'(0): w_rd = SYSID_ID;
      ADDR_W'(1): w_rd = SYSID_TIMESTAMP;
      ADDR_W'(2): w_rd = w_up_lo;
      ADDR_W'(3): w_rd = w_up_hi;
      ADDR_W'(4): w_rd = r_scratch;
      ADDR_W'(5): w_rd = w_ctrl;
      ADDR_W'(6): w_rd = w_info;
      default:    w_rd = '0;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      r_scratch     <= '0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= w_rd;
      if (w_wr && address == ADDR_W'(4)) r_scratch <= writedata;
    end
  end
endmodule

// File: tb/tb_kernel_sysid_regs.sv
// tb_kernel_sysid_regs: directed checks of kernel_sysid_regs register map, timing and uptime snapshot.
module tb_kernel_sysid_regs;
  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  int          n_vec = 0;
  int          n_err = 0;

  kernel_sysid_regs dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
  endtask

  initial begin
`ifdef SYSID_UPTIME_EN
    logic [31:0] info = 32'h00010330;
`else
    logic [31:0] info = 32'h00000330;
`endif
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    tick(); tick();
    chk("rst_data", readdata, 32'h0);
    chk("rst_valid", {31'b0, readdatavalid}, 32'h0);
    reset = 1'b0;
    tick();
    chk("idle_valid", {31'b0, readdatavalid}, 32'h0);
    read = 1'b1; address = 3'd0;
    tick();
    chk("b2b_v0", {31'b0, readdatavalid}, 32'h1);
    chk("id", readdata, 32'h00000001);
    address = 3'd1;
    tick();
    chk("b2b_v1", {31'b0, readdatavalid}, 32'h1);
    chk("ts", readdata, 32'd1503996230);
    address = 3'd6;
    tick();
    chk("b2b_v2", {31'b0, readdatavalid}, 32'h1);
    chk("info", readdata, info);
    read = 1'b0;
    tick();
    chk("after_valid", {31'b0, readdatavalid}, 32'h0);
    chk("hold_data", readdata, info);

    wr(3'd4, 32'hDEADBEEF);
    chk("wr_no_valid", {31'b0, readdatavalid}, 32'h0);
    rd(3'd4);
    chk("scratch", readdata, 32'hDEADBEEF);
    reset = 1'b1; read = 1'b1; address = 3'd4;
    tick();
    chk("rst_mid_read_valid", {31'b0, readdatavalid}, 32'h0);
    reset = 1'b0; read = 1'b0;
    rd(3'd4);
    chk("scratch_rst", readdata, 32'h0);

    wr(3'd0, 32'hFFFFFFFF);
    rd(3'd0);
    chk("id_ro", readdata, 32'h00000001);
    wr(3'd7, 32'h55555555);
    rd(3'd7);
    chk("addr7", readdata, 32'h0);

    wr(3'd4, 32'hA5A5A5A5);
    address = 3'd4; writedata = 32'h12345678; read = 1'b1; write = 1'b1;
    tick();
    read = 1'b0; write = 1'b0;
    chk("rw_old", readdata, 32'hA5A5A5A5);
    rd(3'd4);
    chk("rw_unchanged", readdata, 32'hA5A5A5A5);

`ifdef SYSID_UPTIME_EN
    wr(3'd5, 32'h3);
    rd(3'd5);
    chk("ctrl_rb", readdata, 32'h2);
    rd(3'd2);
    chk("frz_lo0", readdata, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    rd(3'd2);
    chk("frz_lo1", readdata, 32'h0);
    wr(3'd5, 32'h1);
    rd(3'd2);
    chk("clr_lo0", readdata, 32'h0);
    rd(3'd2);
    chk("clr_lo1", readdata, 32'h1);
    rd(3'd5);
    chk("ctrl_rb0", readdata, 32'h0);
    wr(3'd5, 32'h3);
    dut.r_cnt = 48'h0000_FFFF_FFFF;
    wr(3'd5, 32'h0);
    rd(3'd2);
    chk("snap_lo", readdata, 32'hFFFFFFFF);
    rd(3'd3);
    chk("snap_hi", readdata, 32'h0);
    rd(3'd2);
    chk("snap_lo2", readdata, 32'h1);
    rd(3'd3);
    chk("snap_hi2", readdata, 32'h1);
`else
    wr(3'd5, 32'h3);
    rd(3'd5);
    chk("ctrl_off", readdata, 32'h0);
    rd(3'd2);
    chk("uplo_off", readdata, 32'h0);
    rd(3'd3);
    chk("uphi_off", readdata, 32'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/kernel_sysid_regs.md
Name: kernel_sysid_regs

Overview:
- Parametrised system-ID register block and successor to the two-word sysid slave.
- Avalon-MM slave on the kernel system interconnect. Serves:
  - the build ID and timestamp words;
  - a free-running uptime counter with atomic 64-bit snapshot read;
  - a scratch register;
  - a control/info word.
- Registered read path with fixed read latency 1, so software can identify the image and time-stamp events.

Parameters:
- SYSID_ID, 32'h00000001, build ID returned at word 0.
- SYSID_TIMESTAMP, 1503996230, build timestamp returned at word 1.
- ADDR_W, 3, word-address width; legal range 3..8.
- UPTIME_W, 48, uptime counter width; legal range 33..64.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- address  in  ADDR_W  word address.
- read  in  1  read strobe, one cycle per request.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- readdatavalid  out  1  qualifies readdata for one cycle.

Behaviour:
- Clock and reset (already decided): one clock, `clock`. Reset `reset` is synchronous and active-high. All state updates on the rising edge of `clock`.
- Reset values:
  - readdata = 0, readdatavalid = 0.
  - uptime counter = 0, hi_shadow = 0, scratch = 0, freeze = 0.
- Register map (word addresses):
  - 0 ID (RO) = SYSID_ID.
  - 1 TS (RO) = SYSID_TIMESTAMP.
  - 2 UP_LO (RO) = counter[31:0].
  - 3 UP_HI (RO) = hi_shadow.
  - 4 SCRATCH (RW).
  - 5 CTRL: bit1 freeze (RW); bit0 clear (W1, always reads 0); other bits read 0.
  - 6 INFO (RO): [7:0] = UPTIME_W, [11:8] = ADDR_W, [16] = 1 when the optional feature is compiled in; other bits 0.
  - 7 and above: read 0, writes ignored.
- Read latency is exactly 1:
  - read at edge N gives readdatavalid = 1 and valid readdata after edge N+1;
  - readdatavalid is 0 on every cycle without a read the previous cycle;
  - readdata holds its last value when readdatavalid = 0.
- Back-to-back reads every cycle are supported; no waitrequest.
- Counter:
  - Increments by 1 every cycle unless freeze = 1 or clear is written.
  - Wraps from 2^UPTIME_W-1 to 0.
- Snapshot:
  - A read of UP_LO returns counter[31:0] as sampled at the request edge.
  - On that same edge, counter[UPTIME_W-1:32] is loaded into hi_shadow, zero-extended to 32 bits.
  - A read of UP_HI returns hi_shadow and does not update it.
- Clear:
  - A write to CTRL with writedata[0] = 1 sets counter to 0 on that edge.
  - freeze is taken from writedata[1] on the same write.
  - Clear has priority over increment.
- Simultaneous read and write in the same cycle: the read is served, the write is dropped.
- Writes to RO addresses have no effect.
- Reset mid-read: a read request on the reset cycle is discarded and readdatavalid = 0 after that edge.

Optional Feature:
- Macro: SYSID_UPTIME_EN.
- Defined: counter, hi_shadow and CTRL are implemented as described above; INFO[16] = 1.
- Undefined: no counter logic is built.
  - UP_LO, UP_HI and CTRL read 0; writes to them are ignored.
  - INFO[16] = 0.
  - ID, TS, SCRATCH and read timing are unchanged.

Test Plan:
- Reset, then read addresses 0, 1, 6 back-to-back:
  - readdatavalid is high three consecutive cycles;
  - data = 1, 1503996230, 0x00010330.
- Write SCRATCH = 0xDEADBEEF, read it back -> 0xDEADBEEF one cycle after read. Then assert reset, read again -> 0.
- Write CTRL = 0x2 (freeze), read UP_LO twice 10 cycles apart -> identical values. Write CTRL = 0x1 -> next UP_LO read returns a small value (< 4) and increments on later reads.
- Force counter to 0x0000_FFFF_FFFF via clear plus hierarchical deposit, read UP_LO on that edge, then UP_HI:
  - UP_LO = 0xFFFFFFFF and UP_HI = 0x00000000, despite the rollover between the reads;
  - the next UP_LO/UP_HI pair gives UP_HI = 1.
- Assert read and write to SCRATCH in the same cycle with writedata 0x12345678 -> returns the old value; a later read shows SCRATCH unchanged. Read address 7 -> 0.
- Compile without SYSID_UPTIME_EN: UP_LO, UP_HI and CTRL read 0, INFO[16] = 0, ID/TS/SCRATCH tests pass unchanged.
